// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Moore control FSM for the multi-cycle RISC-V core. It steps the shared
// datapath through FETCH -> DECODE -> EXEC -> (MEM) -> COMMIT. There is one
// instruction in flight at a time. The unified memory port uses a req/ack
// handshake. An illegal or SYSTEM opcode enters TRAP, and only reset leaves it.
//
// Handshake: mem_req rises on entry to FETCH or MEM and stays high until
// mem_ack is seen high at a rising clk edge. That edge consumes the ack and
// the FSM leaves the state. mem_ack is ignored whenever mem_req is low. Only
// reset (or a watchdog timeout, when built in) drops mem_req early.
//
// Optional feature: define SEQ_MEM_TIMEOUT_EN to add an 8-bit memory-wait
// watchdog (parameter TIMEOUT_CYCLES, legal 1..255). After TIMEOUT_CYCLES
// request cycles with no ack, the FSM enters TRAP with cause 11.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode[4:0]       instr[6:2] from IR, valid from DECODE onward
//   mem_ack           memory completion
//   branch_taken      ALU compare result, sampled in EXEC
//   mem_req, mem_we   memory request / store strobe
//   addr_sel          memory address: 0=PC, 1=ALU result
//   ir_write          IR load enable (ack during FETCH)
//   pc_write, pc_sel  PC update enable / source (00 PC+4, 01 ALU, 10 branch)
//   alu_src_a/b       ALU operand selects
//   alu_op[1:0]       00 add, 01 branch compare, 10 funct decode, 11 pass B
//   reg_write, wb_sel register write enable / write-back source
//   trap, trap_cause  sticky fault flag and cause
//   state[2:0]        current FSM state (debug)
module multicycle_sequencer
`ifdef SEQ_MEM_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic       mem_ack,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_COMMIT = 3'b101,
    S_TRAP   = 3'b110
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_ARITHI = 5'b00100;
  localparam logic [4:0] OP_ARITHR = 5'b01100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  state_t     state_q, state_next;
  logic [4:0] op_q;
  logic       taken_q;
  logic       trap_q;
  logic [1:0] trap_cause_q, cause_next;
  logic [1:0] dec_cause;
  logic       timeout_hit;

  // The request phase depends only on the state. That keeps the watchdog
  // compare free of any loop through the next-state logic.
  logic req_phase;
  assign req_phase = (state_q == S_FETCH) || (state_q == S_MEM);

  // Instruction class decode from the latched opcode.
  logic is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_arithi, is_arithr, is_auipc, is_lui;
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);
  assign is_arithi = (op_q == OP_ARITHI);
  assign is_arithr = (op_q == OP_ARITHR);
  assign is_auipc  = (op_q == OP_AUIPC);
  assign is_lui    = (op_q == OP_LUI);

  // Legality check on the live opcode, used during DECODE.
  always_comb begin
    dec_cause = 2'b01;
    case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_ARITHI, OP_ARITHR, OP_AUIPC, OP_LUI: dec_cause = 2'b00;
      OP_SYSTEM:                              dec_cause = 2'b10;
      default:                                dec_cause = 2'b01;
    endcase
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  // Fires in the cycle whose missing ack would bring the count to the limit.
  // The request therefore lasts exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = req_phase && !mem_ack &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Counts wait cycles of the current request. It is zero outside FETCH and
  // MEM, so each entry to those states starts from zero. An ack also clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (req_phase && !mem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state and Moore outputs. ir_write is the single Mealy term.
  always_comb begin
    state_next = state_q;
    cause_next = 2'b00;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
        if (mem_ack) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b11;
        end
      end
      S_DECODE: begin
        cause_next = dec_cause;
        state_next = (dec_cause != 2'b00) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (is_branch) begin
          alu_op = 2'b01;
        end else if (is_arithi || is_arithr) begin
          alu_op = 2'b10;
        end else if (is_lui) begin
          alu_op = 2'b11;
        end
        alu_src_b  = !(is_arithr || is_branch);
        alu_src_a  = is_auipc || is_jal;
        state_next = (is_load || is_store) ? S_MEM : S_COMMIT;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ack) begin
          state_next = S_COMMIT;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b11;
        end
      end
      S_COMMIT: begin
        pc_write = 1'b1;
        if (is_jal || is_jalr) begin
          pc_sel = 2'b01;
        end else if (is_branch && taken_q) begin
          pc_sel = 2'b10;
        end
        reg_write = !(is_store || is_branch);
        if (is_load) begin
          wb_sel = 2'b01;
        end else if (is_jal || is_jalr) begin
          wb_sel = 2'b10;
        end
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        // IDLE, and the unreachable 111 encoding, both start a fetch.
        state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 5'd0;
      taken_q      <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
      if (state_q == S_EXEC) begin
        taken_q <= branch_taken;
      end
      // The cause is captured once, on entry to TRAP, and then held.
      if (state_q != S_TRAP && state_next == S_TRAP) begin
        trap_q       <= 1'b1;
        trap_cause_q <= cause_next;
      end
    end
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RISC-V core: a Moore FSM that steps the shared datapath through fetch, decode, execute, memory and commit phases, one instruction at a time. It replaces per-opcode single-cycle decode with per-state control. It drives the unified memory port through a req/ack handshake, and raises a sticky trap on illegal or SYSTEM opcodes.

## Interface
- TIMEOUT_CYCLES, 255: memory-wait watchdog limit (only with SEQ_MEM_TIMEOUT_EN); 8-bit counter, legal 1..255
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  5  instr[6:2] from IR; valid from DECODE onward
- mem_ack  in  1  memory completion; honoured only while mem_req=1
- branch_taken  in  1  ALU compare result; sampled in EXEC
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  store strobe (qualifies mem_req)
- addr_sel  out  1  0=PC, 1=ALU result
- ir_write  out  1  IR load enable
- pc_write  out  1  PC update enable
- pc_sel  out  2  00=PC+4, 01=ALU target (JAL/JALR), 10=branch target
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=imm
- alu_op  out  2  00=add, 01=branch compare, 10=funct decode, 11=pass B
- reg_write  out  1  register file write enable
- wb_sel  out  2  00=ALU, 01=memory data, 10=PC+4
- trap  out  1  sticky fault flag
- trap_cause  out  2  00=none, 01=illegal opcode, 10=SYSTEM, 11=memory timeout
- state  out  3  current state encoding (debug)

## Operation
- States (encoding): IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, COMMIT=101, TRAP=110; 111 unreachable, decodes as IDLE.
- Recognised opcodes: Load 00000, Store 01000, Branch 11000, JAL 11011, JALR 11001, Arith_I 00100, Arith_R 01100, AUIPC 00101, LUI 01101. SYSTEM 11100 traps with cause 10. Every other value, custom-0 (00010) included, traps with cause 01.
- IDLE: all outputs 0; next FETCH unconditionally.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. ir_write = mem_ack (Mealy). Next state is DECODE on ack, otherwise stay.
- DECODE: latch opcode into op_q. Next state is TRAP for an illegal or SYSTEM opcode, otherwise EXEC.
- EXEC (all fields from op_q):
  - alu_op: 00 for Load/Store/AUIPC/JAL/JALR, 01 for Branch, 10 for Arith_I/Arith_R, 11 for LUI.
  - alu_src_b=1 for every class except Arith_R and Branch.
  - alu_src_a=1 for AUIPC and JAL.
  - branch_taken is registered into taken_q.
  - Next state is MEM for Load/Store, otherwise COMMIT.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for Store. Next state is COMMIT on ack, otherwise stay.
- COMMIT: pc_write=1.
  - pc_sel: 01 for JAL/JALR, 10 for Branch with taken_q=1, otherwise 00.
  - reg_write=1 for every class except Store and Branch.
  - wb_sel: 01 for Load, 10 for JAL/JALR, otherwise 00.
  - Next state FETCH.
- TRAP: trap=1, trap_cause held, all other outputs 0. Only reset leaves TRAP.
- EXEC/MEM/COMMIT hold their datapath controls for the whole state. In all other states those controls are 0.

## Timing
- Reset: state=IDLE, op_q=0, taken_q=0, timeout counter=0, trap=0, trap_cause=00. All outputs 0 while rst_n=0.
- Reset asserted mid-handshake drops mem_req asynchronously. After release, the first fetch is issued 2 edges later (IDLE, then FETCH).
- Latency with zero-wait ack (ack in the same cycle as req):
  - ALU/jump/branch: 4 cycles (FETCH, DECODE, EXEC, COMMIT).
  - Load/Store: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_ack outside FETCH/MEM is ignored. A held ack does not skip states: each FETCH/MEM consumes exactly one ack per cycle of presence.
- mem_req never deasserts before ack, except on reset or timeout.
- Illegal opcode: trap=1 on the cycle after DECODE.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to FETCH or MEM and on ack, and increments each cycle mem_req=1 with mem_ack=0.
  - When it reaches TIMEOUT_CYCLES, the next state is TRAP with cause 11 and mem_req drops.
- SEQ_MEM_TIMEOUT_EN undefined: no counter is present, waits are unbounded, and cause 11 is never produced.

## Test plan
- Arith_R (opcode 01100), ack same cycle -> states 001,010,011,101,001. In COMMIT: reg_write=1, wb_sel=00, pc_sel=00, pc_write=1. alu_op=10 in EXEC.
- Load (00000), fetch ack after 2 wait cycles, data ack after 3 -> total 10 cycles. mem_we=0 throughout; addr_sel=1 in MEM; wb_sel=01 in COMMIT.
- Store (01000) -> mem_we=1 only in MEM; COMMIT has reg_write=0. Branch (11000): taken=1 gives pc_sel=10; taken=0 gives pc_sel=00.
- Opcode 00010 -> TRAP, trap_cause=01. Opcode 11100 -> trap_cause=10. Both stay sticky for 20 cycles of ack toggling; rst_n pulse returns state to 000.
- rst_n asserted in MEM while mem_req=1 -> mem_req=0 before the next clk edge. After release: IDLE, then FETCH.
- With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> TRAP, cause 11, after 4 request cycles. Without the macro -> FETCH holds for 1000 cycles.
